// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 8 data bits LSB first, odd parity, stop, ACK check.
// Latency: frame paced by the device clock; done/error registered; tx_start ignored (no backpressure) while busy.
module ps2_host_tx #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int IW = $clog2(INHIBIT_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int FW = $clog2(FILTER_LEN);

    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_DOE  = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    if (CLK_FREQ <= 0 || INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || FILTER_LEN < 2) begin : g_param_check
        $error("ps2_host_tx: invalid parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_flt, clk_fall;
    logic [FW-1:0] flt_cnt;

    // Line idles high, so the conditioning chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_flt   <= 1'b1;
            flt_cnt   <= '0;
            clk_fall  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_i};
            data_sync <= {data_sync[0], ps2_data_i};
            clk_fall  <= 1'b0;
            if (clk_sync[1] == clk_flt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_flt  <= clk_sync[1];
                flt_cnt  <= '0;
                clk_fall <= ~clk_sync[1];
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    state_t        state, state_nxt;
    logic [7:0]    tx_byte, byte_nxt;
    logic          parity, par_nxt;
    logic [3:0]    bitcnt, bitcnt_nxt;
    logic [IW-1:0] icnt, icnt_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          clk_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, error_nxt;
    logic [1:0]    code_nxt;
    logic          timeout;

    assign timeout = (tcnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tx_byte     <= '0;
            parity      <= 1'b0;
            bitcnt      <= '0;
            icnt        <= '0;
            tcnt        <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            state       <= state_nxt;
            tx_byte     <= byte_nxt;
            parity      <= par_nxt;
            bitcnt      <= bitcnt_nxt;
            icnt        <= icnt_nxt;
            tcnt        <= tcnt_nxt;
            ps2_clk_oe  <= clk_oe_nxt;
            ps2_data_oe <= data_oe_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            error       <= error_nxt;
            err_code    <= code_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        byte_nxt    = tx_byte;
        par_nxt     = parity;
        bitcnt_nxt  = bitcnt;
        icnt_nxt    = icnt;
        tcnt_nxt    = tcnt;
        clk_oe_nxt  = 1'b0;
        data_oe_nxt = ps2_data_oe;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;
        code_nxt    = err_code;

        case (state)
            IDLE: begin
                data_oe_nxt = 1'b0;
                if (tx_start) begin
                    state_nxt  = INHIBIT;
                    byte_nxt   = tx_data;
                    par_nxt    = ~^tx_data;
                    code_nxt   = 2'b00;
                    icnt_nxt   = '0;
                    clk_oe_nxt = 1'b1;
                end
            end
            INHIBIT: begin
                clk_oe_nxt = 1'b1;
                icnt_nxt   = icnt + 1'b1;
                // Start bit goes out one cycle before the clock is released.
                if (icnt == INH_DOE) data_oe_nxt = 1'b1;
                if (icnt == INH_LAST) begin
                    state_nxt   = SEND;
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b1;
                    tcnt_nxt    = '0;
                    bitcnt_nxt  = '0;
                end
            end
            SEND: begin
                tcnt_nxt = tcnt + 1'b1;
                if (clk_fall) begin
                    bitcnt_nxt = bitcnt + 4'd1;
                    if (bitcnt < 4'd8) begin
                        data_oe_nxt = ~tx_byte[bitcnt[2:0]];
                    end else if (bitcnt == 4'd8) begin
                        data_oe_nxt = ~parity;
                    end else begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = ACK;
                    end
                end
            end
            ACK: begin
                tcnt_nxt = tcnt + 1'b1;
                if (clk_fall) begin
                    if (!data_sync[1]) begin
                        state_nxt = WAIT_IDLE;
                    end else begin
                        state_nxt = IDLE;
                        error_nxt = 1'b1;
                        code_nxt  = 2'b10;
                    end
                end
            end
            WAIT_IDLE: begin
                tcnt_nxt = tcnt + 1'b1;
                if (clk_sync[1] && data_sync[1]) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Timeout overrides whatever the device did in the same cycle.
        if ((state == SEND || state == ACK || state == WAIT_IDLE) && timeout) begin
            state_nxt   = IDLE;
            data_oe_nxt = 1'b0;
            done_nxt    = 1'b0;
            error_nxt   = 1'b1;
            code_nxt    = 2'b01;
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural keyboard on open-drain lines.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TO  = 3000;
    localparam int FLT = 4;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       kb_clk = 1'b1;
    logic       kb_data = 1'b1;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, error;
    logic [1:0] err_code;

    assign ps2_clk_i  = kb_clk & ~ps2_clk_oe;
    assign ps2_data_i = kb_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_FREQ      (100_000_000),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FLT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always @(negedge clk) begin
        if (done)  done_cnt++;
        if (error) err_cnt++;
    end

    typedef struct {
        logic [7:0]  dat;
        bit          ack;
        bit          glitch;
        bit          poke;
        logic [10:0] bits;   // {stop, parity, d7..d0, start} as seen on the line
        int          dones;
        int          errs;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d, output int inh, output int sbit);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = ~d;
        chk("busy_after_start", int'(busy), 1);
        chk("err_code_cleared", int'(err_code), 0);
        inh = 0;
        while (ps2_clk_oe && inh < INH + 100) begin
            inh++;
            @(negedge clk);
        end
        sbit = int'(ps2_data_oe);
    endtask

    task automatic kb_frame(input bit ack, input bit glitch, input bit poke, output logic [10:0] bits);
        repeat (H) @(negedge clk);
        for (int e = 0; e < 11; e++) begin
            bits[e] = ps2_data_i;
            if (e == 10 && ack) kb_data = 1'b0;
            kb_clk = 1'b0;
            repeat (H) @(negedge clk);
            kb_clk = 1'b1;
            if (poke && e == 3) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (H - 1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            if (glitch && e == 4) begin
                kb_clk = 1'b0;
                repeat (2) @(negedge clk);
                kb_clk = 1'b1;
                repeat (H) @(negedge clk);
            end
        end
        kb_data = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          inh, sbit, d0, e0;
        logic [10:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(v.dat, inh, sbit);
        chk($sformatf("v%0d_inhibit_len", idx), inh, INH);
        chk($sformatf("v%0d_start_bit_oe", idx), sbit, 1);
        kb_frame(v.ack, v.glitch, v.poke, bits);
        repeat (30) @(negedge clk);
        chk($sformatf("v%0d_frame_bits", idx), int'(bits), int'(v.bits));
        chk($sformatf("v%0d_done_pulses", idx), done_cnt - d0, v.dones);
        chk($sformatf("v%0d_error_pulses", idx), err_cnt - e0, v.errs);
        chk($sformatf("v%0d_err_code", idx), int'(err_code), int'(v.code));
        chk($sformatf("v%0d_busy_end", idx), int'(busy), 0);
        chk($sformatf("v%0d_oe_end", idx), int'({ps2_clk_oe, ps2_data_oe}), 0);
    endtask

    initial begin
        int   inh, sbit, cnt, d0, e0;
        vec_t ff_vec;

        vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 11'b1_1_1110_1101_0, 1, 0, 2'b00};
        vecs[1] = '{8'hF4, 1'b1, 1'b0, 1'b0, 11'b1_0_1111_0100_0, 1, 0, 2'b00};
        vecs[2] = '{8'hED, 1'b0, 1'b0, 1'b0, 11'b1_1_1110_1101_0, 0, 1, 2'b10};
        vecs[3] = '{8'hED, 1'b1, 1'b0, 1'b1, 11'b1_1_1110_1101_0, 1, 0, 2'b00};
        vecs[4] = '{8'hED, 1'b1, 1'b1, 1'b0, 11'b1_1_1110_1101_0, 1, 0, 2'b00};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 11'b1_1_0000_0000_0, 1, 0, 2'b00};
        vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b0, 11'b1_0_0000_0001_0, 1, 0, 2'b00};
        ff_vec  = '{8'hFF, 1'b1, 1'b0, 1'b0, 11'b1_1_1111_1111_0, 1, 0, 2'b00};

        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", int'({ps2_clk_oe, ps2_data_oe, busy, done, error, err_code}), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_outputs", int'({ps2_clk_oe, ps2_data_oe, busy, done, error, err_code}), 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Device never clocks: timeout counted from the first cycle with the clock released.
        e0 = err_cnt;
        start_tx(8'hF4, inh, sbit);
        cnt = 0;
        while (!error && cnt < TO + 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("timeout_cycles", cnt, TO);
        chk("timeout_err_code", int'(err_code), 1);
        chk("timeout_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("timeout_busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        chk("timeout_error_pulses", err_cnt - e0, 1);

        // Reset during the inhibit hold must drop the clock pull at once.
        @(negedge clk);
        tx_data  = 8'hED;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("inhibit_before_rst", int'(ps2_clk_oe), 1);
        #2 rst = 1'b0;
        #1 chk("inhibit_rst_release", int'({ps2_clk_oe, ps2_data_oe, busy}), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Reset while data bit 4 (a zero in 0xED) is being driven.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hED, inh, sbit);
        repeat (H) @(negedge clk);
        for (int e = 0; e < 5; e++) begin
            kb_clk = 1'b0;
            repeat (H) @(negedge clk);
            kb_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        chk("bit4_data_oe_before_rst", int'(ps2_data_oe), 1);
        chk("bit4_busy_before_rst", int'(busy), 1);
        #2 rst = 1'b0;
        #1 chk("bit4_rst_release", int'({ps2_clk_oe, ps2_data_oe, busy, done, error}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_error", err_cnt - e0, 0);
        run_vec(ff_vec, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 keyboard port. It is the sending end of the link that the existing PS/2 keyboard receiver reads.
- Sends one command byte to the keyboard, e.g. 0xED (set LEDs), 0xF4 (enable), 0xFF (reset).
- Drives the open-drain ps2_clk/ps2_data lines through output-enable pins and reports completion, acknowledge status and timeout.
- `busy` is fed to the receiver so that it ignores line activity during a transmission.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz (documentation only; the cycle counts below are derived from it).
- INHIBIT_CYCLES, 12000: length of the ps2_clk low hold, 120 us at 100 MHz.
- TIMEOUT_CYCLES, 1_500_000: 15 ms limit from clock release to ACK completion.
- FILTER_LEN, 4: number of consecutive equal synchronized samples required to accept a new ps2_clk level.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- tx_data, input, 8: command byte, captured when tx_start is accepted.
- tx_start, input, 1: one-cycle request.
- ps2_clk_i, input, 1: raw ps2_clk line level.
- ps2_data_i, input, 1: raw ps2_data line level.
- ps2_clk_oe, output, 1: 1 = pull ps2_clk low; 0 = release.
- ps2_data_oe, output, 1: 1 = pull ps2_data low; 0 = release.
- busy, output, 1: high from start acceptance until the done or error pulse.
- done, output, 1: one-cycle pulse when the keyboard has ACKed.
- error, output, 1: one-cycle pulse on failure.
- err_code, output, 2: 00 none, 01 timeout, 10 no ACK. Held until the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous)
  - State IDLE; all outputs 0; both lines released.
  - Reset asserted mid-transfer releases both lines immediately, with no completion pulse.
- Input conditioning
  - ps2_clk_i and ps2_data_i each pass through a 2-FF synchronizer.
  - The synchronized ps2_clk is filtered: the level changes only after FILTER_LEN identical samples.
  - A falling edge is a filtered 1->0 transition, flagged for one cycle. Edge-detection latency is at most 2 + FILTER_LEN cycles.
- Start acceptance
  - tx_start is accepted only in IDLE. tx_start while busy is ignored and does not corrupt the current transfer.
  - On acceptance: latch tx_data; compute parity = ~^tx_data (odd parity); clear err_code; assert busy in the next cycle.
- State machine
  - IDLE: go to INHIBIT on tx_start.
  - INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for INHIBIT_CYCLES.
    - In the final cycle set ps2_data_oe=1 (start bit).
    - Next state SEND, with ps2_clk_oe=0 and the timeout counter cleared.
  - SEND: ps2_clk released. bitcnt counts 0..9 and advances on each ps2_clk falling edge.
    - Falling edges 1..8: ps2_data_oe = ~tx_data[bitcnt], LSB first.
    - Falling edge 9: ps2_data_oe = ~parity.
    - Falling edge 10: ps2_data_oe = 0 (stop bit, line released); go to ACK.
  - ACK: on the next falling edge, sample synchronized ps2_data.
    - Sample 0: go to WAIT_IDLE.
    - Sample 1: error, err_code=10.
  - WAIT_IDLE: wait until synchronized ps2_clk=1 and ps2_data=1, then pulse done and return to IDLE.
- Timeout
  - The counter runs in SEND, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: release both lines, pulse error, set err_code=01, return to IDLE.
  - Timeout has priority over an edge that arrives in the same cycle.
- Output timing
  - done and error are mutually exclusive and never overlap.
  - busy falls in the same cycle as the done or error pulse.
- Line safety
  - ps2_clk_oe is asserted only in INHIBIT.
  - Outside a transfer both OEs are 0.

Test Plan:
- tx_data=0xED with a keyboard model clocking at 12.5 kHz and pulling data low on the 11th edge -> ps2_clk low for 12000 cycles, start bit 0; line bits 1,0,1,1,0,1,1,1, then parity 1, stop 1; done pulses once; err_code=00.
- tx_data=0xF4 -> data bits 0,0,1,0,1,1,1,1, then parity 0; done pulses.
- Model never clocks after the inhibit period -> error pulses exactly 1_500_000 cycles after clock release; err_code=01; both OEs 0.
- Model leaves data high on the ACK edge -> error pulses; err_code=10; no done pulse.
- tx_start=1 with tx_data=0x00 during an active 0xED transfer -> ignored; the 0xED frame on the line is unchanged.
- rst=0 asserted during data bit 4 -> ps2_clk_oe and ps2_data_oe go to 0 without waiting for a clock edge; busy=0. A new 0xFF transfer after reset completes with done.
- Glitch of 2 cycles low on ps2_clk -> no bit advance; the frame still completes correctly.
